cpu_sequencer: RTL and testbench

CPU_SEQUENCER -- requirements
Module: cpu_sequencer

---
 rtl/cpu_sequencer.sv | 135 +++++++++++++
 tb/tb_cpu_sequencer.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_sequencer.sv
// rtl/cpu_sequencer.sv - multi-cycle fetch/decode/execute sequencer for a small load/store CPU
// Instruction word: {opcode[31:27], rd[26:22], rs1[21:17], rs2[16:12], imm[11:0]}.
module cpu_sequencer #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  halt_req,
  input  logic [DATA_WIDTH-1:0] instr,
  input  logic                  eq,
  input  logic                  lt,
  input  logic                  mem_ready,
  output logic [ADDR_WIDTH-1:0] pc,
  output logic [4:0]            rd_addr,
  output logic [4:0]            rs1_addr,
  output logic [4:0]            rs2_addr,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] imm_out,
  output logic                  alu_src_imm,
  output logic                  reg_we,
  output logic                  wb_sel_mem,
  output logic                  mem_req,
  output logic                  mem_we,
  output logic [2:0]            state,
  output logic                  halted,
  output logic                  illegal
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] pc_q, pc_d;
  logic [DATA_WIDTH-1:0] ir_q, ir_d;
  logic                  illegal_q, illegal_d;

  logic [4:0] opcode;
  logic       is_nop, is_alu, is_load, is_store, taken;
  state_t     boundary;

  assign opcode   = ir_q[31:27];
  assign is_nop   = (ir_q == '0);
  assign is_alu   = ~opcode[4];
  assign is_load  = (opcode == 5'h10);
  assign is_store = (opcode == 5'h11);
  assign boundary = halt_req ? S_IDLE : S_FETCH;

  always_comb begin
    taken = 1'b0;
    case (opcode)
      5'h12:   taken = 1'b1;
      5'h13:   taken = eq;
      5'h14:   taken = ~eq;
      5'h15:   taken = lt;
      5'h16:   taken = ~lt & ~eq;
      5'h17:   taken = ~lt;
      5'h18:   taken = lt | eq;
      default: taken = 1'b0;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      ir_q      <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    case (state_q)
      S_IDLE:   if (start) state_d = S_FETCH;
      S_FETCH: begin
        ir_d    = instr;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        if (opcode >= 5'h19) begin
          state_d   = S_HALT;
          illegal_d = 1'b1;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // The only place pc moves, so each instruction advances it exactly once.
        pc_d = taken ? ir_q[ADDR_WIDTH-1:0] : pc_q + ADDR_WIDTH'(1);
        if (is_alu && !is_nop)       state_d = S_WB;
        else if (is_load || is_store) state_d = S_MEM;
        else                          state_d = boundary;
      end
      S_MEM:    if (mem_ready) state_d = is_load ? S_WB : boundary;
      S_WB:     state_d = boundary;
      S_HALT:   state_d = S_HALT;
      default:  state_d = S_IDLE;
    endcase
  end

  // Strobes decode straight from state so an async reset drops them at once.
  assign pc          = pc_q;
  assign rd_addr     = ir_q[26:22];
  assign rs1_addr    = ir_q[21:17];
  assign rs2_addr    = ir_q[16:12];
  assign alu_op      = is_alu ? opcode[3:0] : 4'b0000;
  assign imm_out     = {{(DATA_WIDTH-12){ir_q[11]}}, ir_q[11:0]};
  assign alu_src_imm = is_alu ? ((ir_q[16:12] == 5'd0) && (ir_q[11:0] != 12'd0))
                              : (is_load || is_store);
  assign reg_we      = (state_q == S_WB);
  assign wb_sel_mem  = (state_q == S_WB) && is_load;
  assign mem_req     = (state_q == S_MEM);
  assign mem_we      = (state_q == S_MEM) && is_store;
  assign state       = state_q;
  assign halted      = (state_q == S_HALT);
  assign illegal     = illegal_q;

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb/tb_cpu_sequencer.sv - directed self-checking bench for cpu_sequencer
module tb_cpu_sequencer;
  logic        clk = 1'b0;
  logic        reset, start, halt_req, eq, lt, mem_ready;
  logic [31:0] instr;
  logic [7:0]  pc;
  logic [4:0]  rd_addr, rs1_addr, rs2_addr;
  logic [3:0]  alu_op;
  logic [31:0] imm_out;
  logic        alu_src_imm, reg_we, wb_sel_mem, mem_req, mem_we, halted, illegal;
  logic [2:0]  state;

  int checks = 0;
  int errors = 0;

  int          cyc, we_cnt, we_at, req_cnt, mwe_cnt, sel_cnt;
  logic [31:0] d_imm;
  logic [4:0]  d_rd, d_rs1, d_rs2;
  logic [3:0]  d_op;
  logic        d_src;
  logic [7:0]  exp_pc;

  logic [4:0] br_op    [0:12] = '{5'h13, 5'h13, 5'h14, 5'h14, 5'h15, 5'h15, 5'h16,
                                  5'h16, 5'h16, 5'h17, 5'h17, 5'h18, 5'h18};
  logic       br_eq    [0:12] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0,
                                  1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
  logic       br_lt    [0:12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
                                  1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  logic       br_taken [0:12] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1,
                                  1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0};

  cpu_sequencer #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) dut (
    .clk(clk), .reset(reset), .start(start), .halt_req(halt_req), .instr(instr),
    .eq(eq), .lt(lt), .mem_ready(mem_ready), .pc(pc), .rd_addr(rd_addr),
    .rs1_addr(rs1_addr), .rs2_addr(rs2_addr), .alu_op(alu_op), .imm_out(imm_out),
    .alu_src_imm(alu_src_imm), .reg_we(reg_we), .wb_sel_mem(wb_sel_mem),
    .mem_req(mem_req), .mem_we(mem_we), .state(state), .halted(halted), .illegal(illegal)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rd,
                                     input logic [4:0] rs1, input logic [4:0] rs2,
                                     input logic [11:0] imm);
    return {op, rd, rs1, rs2, imm};
  endfunction

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Runs one instruction from IDLE back to IDLE; mem_ready rises after n_wait MEM cycles.
  task automatic run(input logic [31:0] ins, input int n_wait);
    int mem_cyc;
    mem_cyc = 0;
    cyc = 0; we_cnt = 0; we_at = 0; req_cnt = 0; mwe_cnt = 0; sel_cnt = 0;
    instr = ins; start = 1'b1; halt_req = 1'b1;
    step();
    start = 1'b0;
    while (state != 3'd0 && cyc < 40) begin
      cyc++;
      if (reg_we) begin
        we_cnt++;
        we_at = cyc;
        if (wb_sel_mem) sel_cnt++;
      end
      if (mem_req) req_cnt++;
      if (mem_we) mwe_cnt++;
      if (state == 3'd2) begin
        d_imm = imm_out; d_rd = rd_addr; d_rs1 = rs1_addr; d_rs2 = rs2_addr;
        d_op = alu_op; d_src = alu_src_imm;
      end
      mem_ready = (state == 3'd4) && (mem_cyc == n_wait);
      if (state == 3'd4) mem_cyc++;
      step();
    end
    mem_ready = 1'b0;
    check("run_back_to_idle", state, 0);
  endtask

  task automatic halt_test(input logic [4:0] op);
    instr = mk(op, 5'd1, 5'd2, 5'd3, 12'd4); start = 1'b1; halt_req = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    check("halt_state", state, 6);
    check("halt_halted", halted, 1);
    check("halt_illegal", illegal, 1);
    check("halt_no_we", reg_we, 0);
    check("halt_no_req", mem_req, 0);
    start = 1'b1; halt_req = 1'b1;
    step();
    step();
    check("halt_sticky", state, 6);
    start = 1'b0; halt_req = 1'b0;
    reset = 1'b1;
    #1;
    check("halt_rst_halted", halted, 0);
    check("halt_rst_illegal", illegal, 0);
    check("halt_rst_state", state, 0);
    step();
    reset = 1'b0;
    step();
  endtask

  initial begin
    reset = 1'b1; start = 1'b0; halt_req = 1'b0; eq = 1'b0; lt = 1'b0;
    mem_ready = 1'b0; instr = '0;
    step();
    step();
    check("rst_state", state, 0);
    check("rst_pc", pc, 0);
    check("rst_reg_we", reg_we, 0);
    check("rst_mem_req", mem_req, 0);
    check("rst_imm", imm_out, 0);
    check("rst_halted", halted, 0);
    reset = 1'b0;
    step();
    step();
    mem_ready = 1'b1;
    step();
    check("idle_hold", state, 0);
    mem_ready = 1'b0;

    run(mk(5'h00, 5'd1, 5'd2, 5'd3, 12'd0), 0);
    check("alu_lat", cyc, 4);
    check("alu_we_cnt", we_cnt, 1);
    check("alu_we_at", we_at, 4);
    check("alu_sel", sel_cnt, 0);
    check("alu_rd", d_rd, 1);
    check("alu_rs1", d_rs1, 2);
    check("alu_rs2", d_rs2, 3);
    check("alu_op", d_op, 0);
    check("alu_src", d_src, 0);
    check("alu_pc", pc, 1);

    run(mk(5'h01, 5'd7, 5'd7, 5'd0, 12'hFFB), 0);
    check("imm_val", d_imm, 32'hFFFF_FFFB);
    check("imm_src", d_src, 1);
    check("imm_op", d_op, 1);
    check("imm_pc", pc, 2);

    run(mk(5'h10, 5'd1, 5'd0, 5'd0, 12'd50), 3);
    check("ld_lat", cyc, 8);
    check("ld_req", req_cnt, 4);
    check("ld_we", we_cnt, 1);
    check("ld_sel", sel_cnt, 1);
    check("ld_op", d_op, 0);
    check("ld_pc", pc, 3);

    run(mk(5'h11, 5'd0, 5'd1, 5'd2, 12'd4), 2);
    check("st_lat", cyc, 6);
    check("st_req", req_cnt, 3);
    check("st_mwe", mwe_cnt, 3);
    check("st_we", we_cnt, 0);
    check("st_pc", pc, 4);

    run(32'd0, 0);
    check("nop_lat", cyc, 3);
    check("nop_we", we_cnt, 0);
    check("nop_pc", pc, 5);

    instr = '0; start = 1'b1; halt_req = 1'b0;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("chain_fetch", state, 1);
    halt_req = 1'b1;
    step();
    check("halt_no_abort", state, 2);
    step();
    step();
    check("halt_boundary", state, 0);
    check("chain_pc", pc, 7);

    run(mk(5'h12, 5'd0, 5'd0, 5'd0, 12'd28), 0);
    check("jmp28_lat", cyc, 3);
    check("jmp28_pc", pc, 28);
    eq = 1'b1;
    run(mk(5'h13, 5'd0, 5'd1, 5'd2, 12'd40), 0);
    check("beq_t_pc", pc, 40);
    run(mk(5'h12, 5'd0, 5'd0, 5'd0, 12'd28), 0);
    eq = 1'b0;
    run(mk(5'h13, 5'd0, 5'd1, 5'd2, 12'd40), 0);
    check("beq_nt_pc", pc, 29);
    run(mk(5'h12, 5'd0, 5'd0, 5'd0, 12'd35), 0);
    check("jmp35_pc", pc, 35);

    exp_pc = 8'd35;
    for (int i = 0; i < 13; i++) begin
      logic [7:0] tgt;
      tgt = 8'(50 + 13 * i);
      eq = br_eq[i]; lt = br_lt[i];
      run(mk(br_op[i], 5'd0, 5'd1, 5'd2, {4'd0, tgt}), 0);
      exp_pc = br_taken[i] ? tgt : exp_pc + 8'd1;
      check($sformatf("br%0d_pc", i), pc, exp_pc);
      check($sformatf("br%0d_lat", i), cyc, 3);
    end
    eq = 1'b0; lt = 1'b0;

    run(mk(5'h12, 5'd0, 5'd0, 5'd0, 12'd255), 0);
    check("jmp255_pc", pc, 255);
    run(mk(5'h0F, 5'd3, 5'd4, 5'd0, 12'd0), 0);
    check("wrap_pc", pc, 0);
    check("wrap_lat", cyc, 4);
    check("wrap_op", d_op, 4'hF);
    check("wrap_src", d_src, 0);

    instr = mk(5'h10, 5'd1, 5'd0, 5'd0, 12'd8); start = 1'b1; halt_req = 1'b1;
    step();
    start = 1'b0;
    step();
    step();
    step();
    check("mid_mem_req", mem_req, 1);
    check("mid_mem_pc", pc, 1);
    reset = 1'b1;
    #1;
    check("arst_req", mem_req, 0);
    check("arst_state", state, 0);
    check("arst_pc", pc, 0);
    step();
    reset = 1'b0;
    step();

    halt_test(5'h1F);
    halt_test(5'h19);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
